// File: rtl/beep_sequencer.sv
// rtl/beep_sequencer.sv - priority beep pattern sequencer driving the buzzer tone enable
module beep_sequencer #(
  parameter int CLK_PER_MS = 50000,
  parameter int P0_ON      = 30,
  parameter int P0_N       = 1,
  parameter int P1_ON      = 100,
  parameter int P1_OFF     = 100,
  parameter int P1_N       = 3,
  parameter int P2_ON      = 250,
  parameter int P2_OFF     = 250,
  parameter int P2_N       = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic       stop,
  output logic       buzzer_en,
  output logic       busy,
  output logic [1:0] active,
  output logic       done,
  output logic [1:0] done_id
);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

  localparam logic [15:0] PRESC_MAX = 16'(CLK_PER_MS - 1);
  localparam logic [9:0]  ON0  = 10'(P0_ON);
  localparam logic [9:0]  ON1  = 10'(P1_ON);
  localparam logic [9:0]  ON2  = 10'(P2_ON);
  localparam logic [9:0]  OFF1 = 10'(P1_OFF);
  localparam logic [9:0]  OFF2 = 10'(P2_OFF);
  localparam logic [3:0]  N0   = 4'(P0_N);
  localparam logic [3:0]  N1   = 4'(P1_N);
  localparam logic [3:0]  N2   = 4'(P2_N);

  state_t      state;
  logic [2:0]  pending;
  logic [15:0] presc;
  logic [9:0]  ms_cnt;
  logic [3:0]  beep_cnt;
  logic [9:0]  cur_on;
  logic [9:0]  cur_off;
  logic [3:0]  cur_n;

  logic [2:0]  cand;
  logic        cand_any;
  logic [1:0]  cand_top;
  logic [2:0]  grant_mask;
  logic        grant;
  logic        tick_ms;
  logic        phase_end;
  logic [3:0]  beep_inc;
  logic [9:0]  sel_on;
  logic [9:0]  sel_off;
  logic [3:0]  sel_n;

  // Requests arriving this cycle compete alongside the latched ones.
  always_comb begin
    cand     = pending | req;
    cand_any = |cand;
    if (cand[2])      cand_top = 2'd2;
    else if (cand[1]) cand_top = 2'd1;
    else              cand_top = 2'd0;
    grant_mask = 3'b001 << cand_top;

    grant = 1'b0;
    if (!stop && cand_any) begin
      if (state == S_IDLE) grant = 1'b1;
      else                 grant = (cand_top > active);
    end

    tick_ms = (presc == PRESC_MAX);
    if (state == S_OFF) phase_end = tick_ms && (ms_cnt == cur_off - 10'd1);
    else                phase_end = tick_ms && (ms_cnt == cur_on - 10'd1);

    beep_inc = (beep_cnt == 4'hf) ? beep_cnt : beep_cnt + 4'd1;

    case (cand_top)
      2'd2:    begin sel_on = ON2; sel_off = OFF2;  sel_n = N2; end
      2'd1:    begin sel_on = ON1; sel_off = OFF1;  sel_n = N1; end
      default: begin sel_on = ON0; sel_off = 10'd1; sel_n = N0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pending   <= 3'b000;
      presc     <= 16'd0;
      ms_cnt    <= 10'd0;
      beep_cnt  <= 4'd0;
      cur_on    <= 10'd0;
      cur_off   <= 10'd0;
      cur_n     <= 4'd0;
      buzzer_en <= 1'b0;
      busy      <= 1'b0;
      active    <= 2'd0;
      done      <= 1'b0;
      done_id   <= 2'd0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state     <= S_IDLE;
        pending   <= 3'b000;
        presc     <= 16'd0;
        ms_cnt    <= 10'd0;
        beep_cnt  <= 4'd0;
        buzzer_en <= 1'b0;
        busy      <= 1'b0;
      end else if (grant) begin
        // Fresh start and preemption share this path: straight into ON.
        state     <= S_ON;
        pending   <= cand & ~grant_mask;
        active    <= cand_top;
        cur_on    <= sel_on;
        cur_off   <= sel_off;
        cur_n     <= sel_n;
        presc     <= 16'd0;
        ms_cnt    <= 10'd0;
        beep_cnt  <= 4'd0;
        buzzer_en <= 1'b1;
        busy      <= 1'b1;
      end else begin
        pending <= cand;
        case (state)
          S_ON: begin
            if (phase_end) begin
              presc     <= 16'd0;
              ms_cnt    <= 10'd0;
              beep_cnt  <= beep_inc;
              buzzer_en <= 1'b0;
              if (cur_n != 4'd0 && beep_inc == cur_n) begin
                state   <= S_IDLE;
                busy    <= 1'b0;
                done    <= 1'b1;
                done_id <= active;
              end else begin
                state <= S_OFF;
              end
            end else if (tick_ms) begin
              presc  <= 16'd0;
              ms_cnt <= ms_cnt + 10'd1;
            end else begin
              presc <= presc + 16'd1;
            end
          end
          S_OFF: begin
            if (phase_end) begin
              state     <= S_ON;
              presc     <= 16'd0;
              ms_cnt    <= 10'd0;
              buzzer_en <= 1'b1;
            end else if (tick_ms) begin
              presc  <= 16'd0;
              ms_cnt <= ms_cnt + 10'd1;
            end else begin
              presc <= presc + 16'd1;
            end
          end
          S_IDLE: begin
            buzzer_en <= 1'b0;
            busy      <= 1'b0;
          end
          default: begin
            state     <= S_IDLE;
            buzzer_en <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
